// File: rtl/sync_fifo_hd_if.sv
// rtl/sync_fifo_hd_if.sv - handshake and status bundle for the width-halving FIFO
interface sync_fifo_hd_if #(
  parameter int WI       = 8,
  parameter int LEVLBITS = 5
);
  logic                enable;
  logic                clear;
  logic [2*WI-1:0]     wdata;
  logic                write;
  logic [WI-1:0]       rdata;
  logic                read;
  logic                full;
  logic                empty;
  logic [LEVLBITS-1:0] level;

  modport master (
    output enable, clear, wdata, write, read,
    input  rdata, full, empty, level
  );

  modport slave (
    input  enable, clear, wdata, write, read,
    output rdata, full, empty, level
  );
endinterface

// File: rtl/sync_fifo_hd.sv
// rtl/sync_fifo_hd.sv - synchronous FIFO, 2*WI-bit writes, WI-bit show-ahead reads
// Optional simulation checks compiled in with SYNC_FIFO_HD_ASSERT_EN.
module sync_fifo_hd #(
  parameter int WI       = 8,
  parameter int DEPTH    = 16,
  parameter int LEVLBITS = 5,
  parameter int REGFLAGS = 0
) (
  input logic          clk,
  input logic          reset,
  sync_fifo_hd_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  logic [WI-1:0]       mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       wr_ptr_hi;
  logic [PW-1:0]       rd_ptr;
  logic [LEVLBITS-1:0] level_q;
  logic [LEVLBITS-1:0] level_d;
  logic                full_w;
  logic                empty_w;
  logic                wr_ok;
  logic                rd_ok;

  // Acceptance uses the pre-edge flags; at level 0 a read is refused even with a write.
  assign wr_ok     = bus.enable & ~bus.clear & bus.write & ~full_w;
  assign rd_ok     = bus.enable & ~bus.clear & bus.read & ~empty_w;
  assign wr_ptr_hi = wr_ptr + PW'(1);

  always_comb begin
    level_d = level_q;
    if (bus.enable && bus.clear) begin
      level_d = '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   level_d = level_q + LEVLBITS'(2);
        2'b01:   level_d = level_q - LEVLBITS'(1);
        2'b11:   level_d = level_q + LEVLBITS'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (bus.enable) begin
      level_q <= level_d;
      if (bus.clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + PW'(2);
        if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr]    <= bus.wdata[WI-1:0];
      mem[wr_ptr_hi] <= bus.wdata[2*WI-1:WI];
    end
  end

  generate
    if (REGFLAGS != 0) begin : g_regflags
      logic full_q;
      logic empty_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          full_q  <= 1'b0;
          empty_q <= 1'b1;
        end else if (bus.enable) begin
          full_q  <= (level_d >= LEVLBITS'(DEPTH - 1));
          empty_q <= (level_d == '0);
        end
      end
      assign full_w  = full_q;
      assign empty_w = empty_q;
    end else begin : g_combflags
      assign full_w  = (level_q >= LEVLBITS'(DEPTH - 1));
      assign empty_w = (level_q == '0);
    end
  endgenerate

  assign bus.rdata = mem[rd_ptr];
  assign bus.full  = full_w;
  assign bus.empty = empty_w;
  assign bus.level = level_q;

`ifdef SYNC_FIFO_HD_ASSERT_EN
  // Write+read on an empty FIFO is a defined case (read simply refused), not an underflow.
  always @(posedge clk) begin
    if (!reset && bus.enable && !bus.clear) begin
      if (bus.write && full_w) begin
        $display("@%0t sync_fifo_hd overflow", $time);
        $stop;
      end
      if (bus.read && empty_w && !bus.write) begin
        $display("@%0t sync_fifo_hd underflow", $time);
        $stop;
      end
    end
    if (!reset && (level_q > LEVLBITS'(DEPTH))) begin
      $display("@%0t sync_fifo_hd level overrange", $time);
      $stop;
    end
  end
`endif
endmodule

// File: tb/tb_sync_fifo_hd.sv
// tb/tb_sync_fifo_hd.sv - directed and random bench for sync_fifo_hd, both flag styles
module tb_sync_fifo_hd;
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear;
  logic [15:0] wdata;
  logic        write;
  logic        read;
  int          checks = 0;
  int          errors = 0;

  sync_fifo_hd_if #(.WI(8), .LEVLBITS(5)) bus0 ();
  sync_fifo_hd_if #(.WI(8), .LEVLBITS(5)) bus1 ();

  assign bus0.enable = enable;
  assign bus0.clear  = clear;
  assign bus0.wdata  = wdata;
  assign bus0.write  = write;
  assign bus0.read   = read;
  assign bus1.enable = enable;
  assign bus1.clear  = clear;
  assign bus1.wdata  = wdata;
  assign bus1.write  = write;
  assign bus1.read   = read;

  sync_fifo_hd #(.WI(8), .DEPTH(16), .LEVLBITS(5), .REGFLAGS(0)) u0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  sync_fifo_hd #(.WI(8), .DEPTH(16), .LEVLBITS(5), .REGFLAGS(1)) u1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int lvl, input logic e, input logic f);
    chk({tag, " level r0"}, 32'(bus0.level), 32'(lvl));
    chk({tag, " empty r0"}, 32'(bus0.empty), 32'(e));
    chk({tag, " full r0"},  32'(bus0.full),  32'(f));
    chk({tag, " level r1"}, 32'(bus1.level), 32'(lvl));
    chk({tag, " empty r1"}, 32'(bus1.empty), 32'(e));
    chk({tag, " full r1"},  32'(bus1.full),  32'(f));
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] exp);
    chk({tag, " rdata r0"}, 32'(bus0.rdata), 32'(exp));
    chk({tag, " rdata r1"}, 32'(bus1.rdata), 32'(exp));
  endtask

  initial begin
    logic [7:0] wb;
    logic [7:0] rb;
    int         mlevel;
    logic       do_wr;
    logic       do_rd;

    reset = 1'b1; enable = 1'b1; clear = 1'b0; wdata = '0; write = 1'b0; read = 1'b0;
    repeat (10) tick();
    chk_state("reset", 0, 1'b1, 1'b0);
    reset = 1'b0;
    repeat (2) tick();
    chk_state("idle", 0, 1'b1, 1'b0);

    // single write, two reads
    wdata = 16'h0100; write = 1'b1; tick(); write = 1'b0;
    chk_state("w1", 2, 1'b0, 1'b0);
    chk_rd("w1", 8'h00);
    read = 1'b1; tick();
    chk_state("r1", 1, 1'b0, 1'b0);
    chk_rd("r1", 8'h01);
    tick(); read = 1'b0;
    chk_state("r2", 0, 1'b1, 1'b0);

    // fill completely, then drain
    for (int i = 0; i < 8; i++) begin
      wdata = {8'(2*i+1), 8'(2*i)}; write = 1'b1; tick();
    end
    write = 1'b0;
    chk_state("fill", 16, 1'b0, 1'b1);
    chk_rd("fill", 8'h00);
    read = 1'b1; tick(); read = 1'b0;
    chk_state("full15", 15, 1'b0, 1'b1);
    chk_rd("full15", 8'h01);
    read = 1'b1; tick(); read = 1'b0;
    chk_state("full14", 14, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      chk_rd("drain", 8'(2 + i));
      read = 1'b1; tick(); read = 1'b0;
    end
    chk_state("drained", 0, 1'b1, 1'b0);

    // write+read at level 14
    for (int i = 0; i < 7; i++) begin
      wdata = {8'(8'h21 + 2*i), 8'(8'h20 + 2*i)}; write = 1'b1; tick();
    end
    write = 1'b0;
    chk_state("lvl14", 14, 1'b0, 1'b0);
    wdata = 16'hAAAB; write = 1'b1; read = 1'b1; tick(); write = 1'b0; read = 1'b0;
    chk_state("wr14", 15, 1'b0, 1'b1);
    chk_rd("wr14", 8'h21);
    for (int i = 0; i < 15; i++) begin
      chk_rd("drain2", (i < 13) ? 8'(8'h21 + i) : ((i == 13) ? 8'hAB : 8'hAA));
      read = 1'b1; tick(); read = 1'b0;
    end
    chk_state("drained2", 0, 1'b1, 1'b0);

    // write+read at level 0: read refused
    wdata = 16'h5150; write = 1'b1; read = 1'b1; tick(); write = 1'b0; read = 1'b0;
    chk_state("wr0", 2, 1'b0, 1'b0);
    chk_rd("wr0", 8'h50);

    // reach level 9, freeze, clear
    for (int i = 0; i < 4; i++) begin
      wdata = {8'(8'h61 + 2*i), 8'(8'h60 + 2*i)}; write = 1'b1; tick();
    end
    write = 1'b0;
    read = 1'b1; tick(); read = 1'b0;
    chk_state("lvl9", 9, 1'b0, 1'b0);
    chk_rd("lvl9", 8'h51);
    enable = 1'b0; write = 1'b1; read = 1'b1; wdata = 16'hEEEE;
    repeat (2) tick();
    write = 1'b0; read = 1'b0; enable = 1'b1;
    chk_state("frozen9", 9, 1'b0, 1'b0);
    chk_rd("frozen9", 8'h51);
    clear = 1'b1; write = 1'b1; read = 1'b1; tick();
    clear = 1'b0; write = 1'b0; read = 1'b0;
    chk_state("clear", 0, 1'b1, 1'b0);
    enable = 1'b0; write = 1'b1; wdata = 16'h7170;
    repeat (3) tick();
    write = 1'b0; enable = 1'b1;
    chk_state("frozen0", 0, 1'b1, 1'b0);
    wdata = 16'h8180; write = 1'b1; tick();
    wdata = 16'h8382; tick(); write = 1'b0;
    chk_state("refill", 4, 1'b0, 1'b0);
    chk_rd("refill", 8'h80);
    reset = 1'b1; #1;
    chk_state("async_rst", 0, 1'b1, 1'b0);
    tick(); reset = 1'b0; tick();

    // random traffic against a level model
    wb = 8'h00; rb = 8'h00; mlevel = 0;
    for (int c = 0; c < 4000; c++) begin
      do_wr = ($urandom_range(3) != 0) && (mlevel < 15);
      do_rd = ($urandom_range(1) == 1) && (mlevel != 0);
      write = do_wr; read = do_rd; wdata = {wb + 8'h01, wb};
      if (do_rd) begin
        chk_rd("rand", rb);
        rb = rb + 8'h01;
      end
      if (do_wr) wb = wb + 8'h02;
      mlevel = mlevel + (do_wr ? 2 : 0) - (do_rd ? 1 : 0);
      tick();
      if ((c % 16) == 0)
        chk_state("rand", mlevel, mlevel == 0, mlevel >= 15);
    end
    write = 1'b0; read = 1'b0;
    chk_state("rand_end", mlevel, mlevel == 0, mlevel >= 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
